// File: rtl/reg_file_multiport_pkg.sv
// Shared types for the multi-read-port register file.
package reg_file_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/reg_file_multiport_if.sv
// Read/write bus of the multi-read-port register file, grouped for module ports.
interface reg_file_multiport_if #(
  parameter int WIDTH        = 32,
  parameter int LOG2NUMREGS  = 5,
  parameter int NUMREADPORTS = 2
);
  logic                                  ready;
  logic [NUMREADPORTS*LOG2NUMREGS-1:0]   rd_reg;
  logic [NUMREADPORTS-1:0]               rd_en;
  logic [NUMREADPORTS*WIDTH-1:0]         rd_data;
  logic [LOG2NUMREGS-1:0]                c_reg;
  logic [WIDTH-1:0]                      c_writedatain;
  logic                                  c_we;
  logic                                  c_squashn;

  modport master (
    input  ready, rd_data,
    output rd_reg, rd_en, c_reg, c_writedatain, c_we, c_squashn
  );

  modport slave (
    output ready, rd_data,
    input  rd_reg, rd_en, c_reg, c_writedatain, c_we, c_squashn
  );
endinterface

// File: rtl/reg_file_bank.sv
// One RAM bank: single write port, one registered read port with old-data
// semantics on a same-edge read/write collision.
module reg_file_bank #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LOG2NUMREGS-1:0] waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   re,
  input  logic [LOG2NUMREGS-1:0] raddr,
  output logic [WIDTH-1:0]       rdata
);
  logic [WIDTH-1:0] mem_q [NUMREGS];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/reg_file_multiport.sv
// Register file with NUMREADPORTS read ports (one replicated bank each), a
// squashable write port, a post-reset zeroing sweep and per-port bypass.
module reg_file_multiport
  import reg_file_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 32,
  parameter int LOG2NUMREGS  = 5,
  parameter int NUMREADPORTS = 2,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 1
) (
  input logic                 clk,
  input logic                 reset,
  reg_file_multiport_if.slave bus
);
  localparam logic [LOG2NUMREGS-1:0] LAST_IDX = LOG2NUMREGS'(NUMREGS - 1);

  state_e                  state_d, state_q;
  logic [LOG2NUMREGS-1:0]  cnt_d, cnt_q;
  logic                    init_active;
  logic                    ext_we;
  logic                    bank_we;
  logic [LOG2NUMREGS-1:0]  bank_waddr;
  logic [WIDTH-1:0]        bank_wdata;

  logic [NUMREADPORTS-1:0]            zero_d, zero_q;
  logic [NUMREADPORTS-1:0]            byp_d, byp_q;
  logic [NUMREADPORTS-1:0][WIDTH-1:0] byp_data_d, byp_data_q;
  logic [NUMREADPORTS-1:0][WIDTH-1:0] bank_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    init_active = (state_q == INIT);
    ext_we      = bus.c_we && bus.c_squashn && !init_active &&
                  !((ZERO_REG != 0) && (bus.c_reg == '0));
    bank_we     = !reset && (init_active || ext_we);
    bank_waddr  = init_active ? cnt_q : bus.c_reg;
    bank_wdata  = init_active ? '0 : bus.c_writedatain;
  end

  // The bank already holds its read data between captures; these flags hold
  // which source (zero, bypass, RAM) the captured read resolved to.
  always_comb begin
    zero_d     = zero_q;
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    for (int unsigned i = 0; i < NUMREADPORTS; i++) begin
      if (bus.rd_en[i]) begin
        zero_d[i]     = init_active ||
                        ((ZERO_REG != 0) && (bus.rd_reg[i*LOG2NUMREGS +: LOG2NUMREGS] == '0));
        byp_d[i]      = (BYPASS != 0) && ext_we &&
                        (bus.rd_reg[i*LOG2NUMREGS +: LOG2NUMREGS] == bus.c_reg);
        byp_data_d[i] = bus.c_writedatain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      zero_q     <= '1;
      byp_q      <= '0;
      byp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
    end
  end

  for (genvar g = 0; g < NUMREADPORTS; g++) begin : g_bank
    reg_file_bank #(
      .WIDTH       (WIDTH),
      .NUMREGS     (NUMREGS),
      .LOG2NUMREGS (LOG2NUMREGS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (bus.rd_en[g]),
      .raddr (bus.rd_reg[g*LOG2NUMREGS +: LOG2NUMREGS]),
      .rdata (bank_rdata[g])
    );
  end

  always_comb begin
    bus.ready   = (state_q == RUN);
    bus.rd_data = '0;
    for (int unsigned i = 0; i < NUMREADPORTS; i++) begin
      if (zero_q[i])     bus.rd_data[i*WIDTH +: WIDTH] = '0;
      else if (byp_q[i]) bus.rd_data[i*WIDTH +: WIDTH] = byp_data_q[i];
      else               bus.rd_data[i*WIDTH +: WIDTH] = bank_rdata[i];
    end
  end
endmodule

// File: doc/reg_file_multiport.md
# reg_file_multiport

Parametrised scalar register file with NUMREADPORTS independent synchronous read ports and one squashable write port, replicated as one RAM bank per read port. A hardware init sequencer zeroes every register after reset, and a per-port bypass path gives selectable read-during-write semantics. It sits in the decode stage of the scalar pipeline as the drop-in successor to the fixed two-read-port register file.

## Interface
- WIDTH, 32, data width in bits
- NUMREGS, 32, number of registers
- LOG2NUMREGS, 5, register index width
- NUMREADPORTS, 2, number of read ports (≥1)
- BYPASS, 1, 1: read-during-write to the same register returns new data; 0: returns old data
- ZERO_REG, 1, 1: register 0 is hardwired to zero
---
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ready  out  1  high once the init sweep has completed
- rd_reg  in  NUMREADPORTS*LOG2NUMREGS  read addresses; port i at [i*LOG2NUMREGS +: LOG2NUMREGS]
- rd_en  in  NUMREADPORTS  per-port read enable (address capture)
- rd_data  out  NUMREADPORTS*WIDTH  read data; port i at [i*WIDTH +: WIDTH]
- c_reg  in  LOG2NUMREGS  write address
- c_writedatain  in  WIDTH  write data
- c_we  in  1  write enable
- c_squashn  in  1  active-low squash; 0 suppresses the write

## Operation
- States: INIT, RUN. Reset forces INIT and init counter = 0.
- INIT: each cycle, write 0 to address init counter in all banks, then increment the counter. After the write to NUMREGS-1, go to RUN. External writes are ignored. Reads are accepted, but rd_data is forced to 0.
- RUN: effective write = c_we & c_squashn & !(ZERO_REG & c_reg==0). The write lands in every bank on the same edge. The squash applies to all banks.
- Read port i: on an edge with rd_en[i]=1, capture rd_reg[i]. rd_data[i] is then registered and holds until the next rd_en[i] capture. Later writes to that register do not change a held value.
- ZERO_REG=1: reading register 0 returns 0, regardless of RAM contents.
- Read-during-write: rd_en[i]=1 and an effective write to the same address on the same edge.
  - BYPASS=1: rd_data[i] = c_writedatain.
  - BYPASS=0: rd_data[i] = the prior contents.
- Reset asserted at any point, including mid-sweep or mid-read: return to INIT, counter = 0, ready=0, all rd_data=0. The sweep restarts from register 0.

## Timing
- Reset values: ready=0, rd_data=0 on all ports, state=INIT, init counter=0.
- Init length: the first clear write happens on the first edge with reset low. ready goes high exactly NUMREGS cycles after reset deasserts.
- Read latency: 1 cycle. The address is presented with rd_en at edge t, and data is valid after edge t, i.e. during cycle t+1.
- Write latency: data written at edge t is visible to a read captured at edge t+1, or at edge t if BYPASS=1.
- Counter width: LOG2NUMREGS bits. The terminal check is counter == NUMREGS-1, so non-power-of-two NUMREGS is supported.

## Structure
- Package reg_file_pkg: the state enum (INIT, RUN).
- Sub-module reg_file_bank: one write port and one registered-address read port, WIDTH×NUMREGS, with old-data mixed-port semantics. NUMREADPORTS instances are generated.
- Top level owns: the init sequencer, write-enable and address muxing (sweep vs. external), per-port bypass compare, zero-register masking, and the output hold registers.

## Test plan
- Reset 3 cycles, then release, with NUMREGS=32 → ready low for exactly 32 cycles, then high. Every register read on every port returns 0.
- In RUN, write 0xDEADBEEF to r5; next cycle read r5 on all ports → all return 0xDEADBEEF. Same write with c_squashn=0 → reads return 0.
- Write 0x12345678 to r0 with ZERO_REG=1, then read r0 → 0. With ZERO_REG=0 → 0x12345678.
- r7=0x1; same edge: write r7=0x2 and read r7 on port 0 → BYPASS=1 returns 0x2, BYPASS=0 returns 0x1. In both cases, a re-read next cycle returns 0x2.
- Capture r3=0xA on port 1, then hold rd_en[1]=0 while writing r3=0xB → rd_data[1] stays 0xA until the next rd_en[1] capture, which returns 0xB.
- Write r9=0x55, then assert reset at sweep count 10, then release → ready low for a further 32 cycles, rd_data=0 meanwhile, and r9 reads 0 after ready.
